// File: rtl/adc_128s_fc.sv
// -----------------------------------------------------------------------------
// adc_128s_fc
//
// Behavioural stand-in for an ADC128S-family SPI ADC. The chip is an SPI
// mode-3 slave that returns the 12-bit value of one of eight channels. The
// channel returned in a frame is the one chosen by the command word of the
// previous frame, so there is a one-frame pipeline. All SPI pins are
// asynchronous to clk. They are synchronized and sampled as ordinary data;
// the design never uses SCLK as a clock.
//
// Ports
//   clk          in   system clock; all state changes on its rising edge
//   rst          in   synchronous active-high reset
//   SS_n         in   SPI slave select, active low (asynchronous)
//   SCLK         in   SPI serial clock, idle high (asynchronous)
//   MOSI         in   SPI data from the master
//   MISO         out  SPI data to the master; driven low while deselected
//   ld_cell_lft  in   channel 0 analog value (12 bits)
//   ld_cell_rght in   channel 4 analog value (12 bits)
//   steerPot     in   channel 5 analog value (12 bits)
//   batt         in   channel 6 analog value (12 bits)
//   Channels 1, 2, 3 and 7 read as 12'h000.
// -----------------------------------------------------------------------------
module adc_128s_fc (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] ld_cell_lft,
  input  logic [11:0] ld_cell_rght,
  input  logic [11:0] steerPot,
  input  logic [11:0] batt
);

  // Frame-level state.
  // ST_UNARMED: entered on reset. The chip waits here until it sees SS_n high
  //   through a flushed synchronizer. A reset that lands mid-frame therefore
  //   cannot resume that frame when SS_n is still low afterwards.
  // ST_IDLE:    deselected; the next SS_n fall starts a frame.
  // ST_FRAME:   selected; SCLK edges are acted on.
  typedef enum logic [1:0] {
    ST_UNARMED = 2'd0,
    ST_IDLE    = 2'd1,
    ST_FRAME   = 2'd2
  } state_e;

  localparam logic [4:0] BITS_PER_FRAME = 5'd16;

  // ---------------------------------------------------------------------------
  // Synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic ss_n_ff1_q, ss_n_ff2_q, ss_n_prev_q;
  logic sclk_ff1_q, sclk_ff2_q, sclk_prev_q;
  logic mosi_ff1_q, mosi_ff2_q;
  logic [1:0] flush_q, flush_d;

  // NOTE: every clocked register is assigned with <= so that all flops sample
  // their inputs from the same edge. With = the second flop of a synchronizer
  // would collapse into the first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_n_ff1_q  <= 1'b1;
      ss_n_ff2_q  <= 1'b1;
      ss_n_prev_q <= 1'b1;
      sclk_ff1_q  <= 1'b1;
      sclk_ff2_q  <= 1'b1;
      sclk_prev_q <= 1'b1;
      mosi_ff1_q  <= 1'b0;
      mosi_ff2_q  <= 1'b0;
      flush_q     <= 2'd0;
    end else begin
      ss_n_ff1_q  <= SS_n;
      ss_n_ff2_q  <= ss_n_ff1_q;
      ss_n_prev_q <= ss_n_ff2_q;
      sclk_ff1_q  <= SCLK;
      sclk_ff2_q  <= sclk_ff1_q;
      sclk_prev_q <= sclk_ff2_q;
      mosi_ff1_q  <= MOSI;
      mosi_ff2_q  <= mosi_ff1_q;
      flush_q     <= flush_d;
    end
  end

  // Reset loads the synchronizers with idle values. ss_n_ff2_q reflects the
  // real pin only after two edges, so flush_q counts those edges before the
  // FSM trusts it.
  always_comb begin
    flush_d = flush_q;
    if (flush_q != 2'd2) begin
      flush_d = flush_q + 2'd1;
    end
  end

  logic sync_valid;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  assign sync_valid = (flush_q == 2'd2);
  assign ss_fall    =  ss_n_prev_q & ~ss_n_ff2_q;
  assign ss_rise    = ~ss_n_prev_q &  ss_n_ff2_q;
  assign sclk_rise  = ~sclk_prev_q &  sclk_ff2_q;
  assign sclk_fall  =  sclk_prev_q & ~sclk_ff2_q;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_UNARMED;
    end else begin
      state_q <= state_d;
    end
  end

  logic frame_start, frame_end, in_frame;

  // NOTE: every signal driven here gets a default value before the case. Any
  // path that leaves a signal unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    in_frame    = 1'b0;
    case (state_q)
      ST_UNARMED: begin
        if (sync_valid && ss_n_ff2_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (ss_fall) begin
          state_d     = ST_FRAME;
          frame_start = 1'b1;
        end
      end
      ST_FRAME: begin
        in_frame = 1'b1;
        if (ss_rise) begin
          state_d   = ST_IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_d = ST_UNARMED;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: channel pointer, tx/rx shift registers, bit counter
  // ---------------------------------------------------------------------------
  logic [2:0]  ptr_q, ptr_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        seen_rise_q, seen_rise_d;
  logic [11:0] chan_val;

  // Channel mux. The value is read only at frame start, so later changes on
  // the analog inputs cannot reach the word being shifted out.
  always_comb begin
    chan_val = 12'h000;
    case (ptr_q)
      3'd0:    chan_val = ld_cell_lft;
      3'd4:    chan_val = ld_cell_rght;
      3'd5:    chan_val = steerPot;
      3'd6:    chan_val = batt;
      default: chan_val = 12'h000;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    seen_rise_d = seen_rise_q;

    if (frame_start) begin
      // A single synchronized SS_n cannot rise and fall in the same cycle.
      // A rise one cycle earlier has therefore already updated ptr_q, and
      // this load uses the new pointer.
      tx_d        = {4'b0000, chan_val};
      rx_d        = 16'h0000;
      cnt_d       = 5'd0;
      seen_rise_d = 1'b0;
    end else if (in_frame) begin
      if (sclk_rise) begin
        rx_d        = (rx_q << 1) | {15'd0, mosi_ff2_q};
        seen_rise_d = 1'b1;
        if (cnt_q != BITS_PER_FRAME) begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      // The first SCLK fall of a frame comes before any data bit. tx[15]
      // must stay on MISO for that fall, so no shift happens yet.
      if (sclk_fall && seen_rise_q) begin
        tx_d = tx_q << 1;
      end
      // Only a complete 16-bit frame may retarget the pointer. A short frame
      // leaves the previous channel selected.
      if (frame_end && (cnt_q == BITS_PER_FRAME)) begin
        ptr_d = rx_q[13:11];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= 3'd0;
      tx_q        <= 16'h0000;
      rx_q        <= 16'h0000;
      cnt_q       <= 5'd0;
      seen_rise_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      seen_rise_q <= seen_rise_d;
    end
  end

  // MISO is forced low outside a frame, and the output is never tri-stated.
  assign MISO = in_frame ? tx_q[15] : 1'b0;

endmodule

// File: tb/tb_adc_128s_fc.sv
// -----------------------------------------------------------------------------
// tb_adc_128s_fc
//
// Self-checking bench for adc_128s_fc. A table of frames sets the analog
// inputs, sends one command word and states the word the DUT must return.
// Each expected word is queued when its frame starts and popped when the
// frame's read data is complete. Hand-written sequences cover these cases:
// back-to-back frames separated by a one-cycle SS_n gap, SCLK activity while
// the DUT is deselected, an aborted short frame, and a reset in mid-frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_128s_fc;

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [11:0] ld_cell_lft;
  logic [11:0] ld_cell_rght;
  logic [11:0] steerPot;
  logic [11:0] batt;

  always #5 clk = ~clk;

  adc_128s_fc dut (
    .clk         (clk),
    .rst         (rst),
    .SS_n        (SS_n),
    .SCLK        (SCLK),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .ld_cell_lft (ld_cell_lft),
    .ld_cell_rght(ld_cell_rght),
    .steerPot    (steerPot),
    .batt        (batt)
  );

  typedef struct {
    logic [15:0] cmd;
    logic [11:0] lft;
    logic [11:0] rght;
    logic [11:0] steer;
    logic [11:0] bat;
    bit          mid_chg;   // change ld_cell_rght after the 8th bit
    logic [11:0] mid_val;
    logic [15:0] exp;       // word MISO must deliver in this frame
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  vec_t        vecs[14];

  function automatic vec_t mk(input logic [15:0] cmd, input logic [11:0] lft,
                              input logic [11:0] rght, input logic [11:0] steer,
                              input logic [11:0] bat, input bit mid_chg,
                              input logic [11:0] mid_val, input logic [15:0] exp);
    vec_t v;
    v.cmd = cmd; v.lft = lft; v.rght = rght; v.steer = steer; v.bat = bat;
    v.mid_chg = mid_chg; v.mid_val = mid_val; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pops the oldest expected word and compares it with the read data.
  task automatic score(input string name, input logic [15:0] rd);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %h, expected queue empty", name, rd);
    end else begin
      check(name, rd, exp_q.pop_front());
    end
  endtask

  // Mode-3 bit loop; SS_n must already be low. The SCLK period is 10 clk.
  // MISO is sampled just before each rising SCLK edge.
  task automatic spi_bits(input logic [15:0] cmd, input int nbits, input bit mid_chg,
                          input logic [11:0] mid_val, output logic [15:0] rd);
    rd = 16'h0000;
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      wait_clk(5);
      rd[15-i] = MISO;
      SCLK = 1'b1;
      wait_clk(5);
      if (mid_chg && i == 7) ld_cell_rght = mid_val;
    end
  endtask

  task automatic full_frame(input string name, input logic [15:0] cmd, input bit mid_chg,
                            input logic [11:0] mid_val, input logic [15:0] exp);
    logic [15:0] rd;
    exp_q.push_back(exp);
    SS_n = 1'b0;
    wait_clk(6);
    spi_bits(cmd, 16, mid_chg, mid_val, rd);
    wait_clk(6);
    SS_n = 1'b1;
    wait_clk(8);
    score(name, rd);
  endtask

  initial begin
    logic [15:0] rd;

    // Pointer trace: 0 ->0 ->5 ->6 ->4 ->4 ->3 ->0 ->6 ->1 ->5 ->7 ->0 ->2 ->0
    vecs[0]  = mk(16'h0000, 12'h400, 12'h400, 12'h800, 12'hFFF, 1'b0, 12'h000, 16'h0400);
    vecs[1]  = mk(16'h2800, 12'h400, 12'h400, 12'h800, 12'hFFF, 1'b0, 12'h000, 16'h0400);
    vecs[2]  = mk(16'h3000, 12'h400, 12'h400, 12'h800, 12'hFFF, 1'b0, 12'h000, 16'h0800);
    vecs[3]  = mk(16'h2000, 12'h400, 12'h400, 12'h800, 12'hFFF, 1'b0, 12'h000, 16'h0FFF);
    vecs[4]  = mk(16'h2000, 12'h400, 12'h400, 12'h800, 12'hFFF, 1'b1, 12'h000, 16'h0400);
    vecs[5]  = mk(16'h1800, 12'h400, 12'h000, 12'h800, 12'hFFF, 1'b0, 12'h000, 16'h0000);
    vecs[6]  = mk(16'h0000, 12'h400, 12'h000, 12'h800, 12'hFFF, 1'b0, 12'h000, 16'h0000);
    vecs[7]  = mk(16'hF7FF, 12'hABC, 12'h000, 12'h800, 12'hFFF, 1'b0, 12'h000, 16'h0ABC);
    vecs[8]  = mk(16'h0800, 12'hABC, 12'h000, 12'h800, 12'h5A5, 1'b0, 12'h000, 16'h05A5);
    vecs[9]  = mk(16'h2800, 12'hABC, 12'h000, 12'h800, 12'h5A5, 1'b0, 12'h000, 16'h0000);
    vecs[10] = mk(16'h3800, 12'hABC, 12'h000, 12'h123, 12'h5A5, 1'b0, 12'h000, 16'h0123);
    vecs[11] = mk(16'h0000, 12'hABC, 12'h000, 12'h123, 12'h5A5, 1'b0, 12'h000, 16'h0000);
    vecs[12] = mk(16'h1000, 12'hABC, 12'h000, 12'h123, 12'h5A5, 1'b0, 12'h000, 16'h0ABC);
    vecs[13] = mk(16'h0000, 12'hABC, 12'h000, 12'h123, 12'h5A5, 1'b0, 12'h000, 16'h0000);

    // Reset with the bus idle.
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    ld_cell_lft = 12'h000; ld_cell_rght = 12'h000; steerPot = 12'h000; batt = 12'h000;
    wait_clk(4);
    check("miso_in_reset", {15'd0, MISO}, 16'h0000);
    rst = 1'b0;
    wait_clk(6);

    // Table-driven frames.
    for (int i = 0; i < 14; i++) begin
      ld_cell_lft  = vecs[i].lft;
      ld_cell_rght = vecs[i].rght;
      steerPot     = vecs[i].steer;
      batt         = vecs[i].bat;
      full_frame($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].mid_chg,
                 vecs[i].mid_val, vecs[i].exp);
    end

    // SS_n high for one clk between frames. The pointer update from the first
    // frame must reach the tx load of the second frame.
    exp_q.push_back(16'h0ABC);
    SS_n = 1'b0;
    wait_clk(6);
    spi_bits(16'h3000, 16, 1'b0, 12'h000, rd);
    wait_clk(6);
    SS_n = 1'b1;
    wait_clk(1);
    SS_n = 1'b0;
    score("adj_first", rd);
    exp_q.push_back(16'h05A5);
    wait_clk(6);
    spi_bits(16'h2000, 16, 1'b0, 12'h000, rd);
    wait_clk(6);
    SS_n = 1'b1;
    wait_clk(8);
    score("adj_second", rd);

    // The last frame leaves tx[15] = 1 (bit 0 of 5A5), but MISO must be low.
    check("miso_idle", {15'd0, MISO}, 16'h0000);

    // SCLK activity while deselected is ignored; the pointer stays at ch4.
    for (int i = 0; i < 16; i++) begin
      SCLK = 1'b0;
      MOSI = 1'($urandom_range(0, 1));
      wait_clk(4);
      SCLK = 1'b1;
      wait_clk(4);
    end
    check("miso_idle_sclk", {15'd0, MISO}, 16'h0000);
    ld_cell_rght = 12'h777;
    full_frame("after_idle_sclk", 16'h2000, 1'b0, 12'h000, 16'h0777);

    // Abort after 8 bits of a ch6 command; the pointer must stay at ch4.
    SS_n = 1'b0;
    wait_clk(6);
    spi_bits(16'h3000, 8, 1'b0, 12'h000, rd);
    wait_clk(6);
    SS_n = 1'b1;
    wait_clk(8);
    check("abort_partial", {8'h00, rd[15:8]}, 16'h0007);
    full_frame("after_abort", 16'h3000, 1'b0, 12'h000, 16'h0777);

    // Reset in mid-frame with the pointer at ch6. SS_n stays low across the
    // reset, and the SCLK toggles that follow must not start a frame.
    ld_cell_lft = 12'hFFF;
    SS_n = 1'b0;
    wait_clk(6);
    spi_bits(16'h3800, 5, 1'b0, 12'h000, rd);
    rst = 1'b1;
    wait_clk(1);
    check("miso_mid_reset", {15'd0, MISO}, 16'h0000);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 6; i++) begin
      SCLK = 1'b0;
      wait_clk(5);
      if (i == 5) check("miso_no_frame_after_reset", {15'd0, MISO}, 16'h0000);
      SCLK = 1'b1;
      wait_clk(5);
    end
    SS_n = 1'b1;
    wait_clk(8);
    full_frame("after_reset", 16'h0000, 1'b0, 12'h000, 16'h0FFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_128s_fc.md
ADC_128S_FC -- requirements
Module: adc_128s_fc

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; all internal state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port SS_n, input, 1 bit: SPI slave select, active low, asynchronous to clk.
REQ-004 SHALL have port SCLK, input, 1 bit: SPI serial clock, idle high, asynchronous to clk.
REQ-005 SHALL have port MOSI, input, 1 bit: SPI serial data from the master.
REQ-006 SHALL have port MISO, output, 1 bit: SPI serial data to the master.
REQ-007 SHALL have port ld_cell_lft, input, 12 bits: analog value for channel 0.
REQ-008 SHALL have port ld_cell_rght, input, 12 bits: analog value for channel 4.
REQ-009 SHALL have port steerPot, input, 12 bits: analog value for channel 5.
REQ-010 SHALL have port batt, input, 12 bits: analog value for channel 6.

Function
REQ-011 SHALL pass SS_n, SCLK and MOSI through two-flop synchronizers into clk, and detect SCLK and SS_n edges from the synchronized values.
REQ-012 SHALL operate in SPI mode 3: MOSI sampled on SCLK rise, MISO updated on SCLK fall.
REQ-013 SHALL support an SCLK period of at least 8 clk cycles.
REQ-014 SHALL define a frame as SS_n falling, exactly 16 SCLK rising edges, then SS_n rising.
REQ-015 SHALL, on the synchronized SS_n fall, load a 16-bit tx shift register with {4'b0000, value}, where value is the selected channel's input snapshotted at that clk.
REQ-016 SHALL, mid-frame, ignore changes on the analog inputs.
REQ-017 SHALL drive MISO from tx[15] while SS_n is low.
REQ-018 SHALL shift tx left by 1 (zero fill) on each SCLK fall that follows at least one SCLK rise in the frame.
REQ-019 SHALL use channel map 0=ld_cell_lft, 4=ld_cell_rght, 5=steerPot, 6=batt, and 1,2,3,7 = 12'h000.
REQ-020 SHALL, on each synchronized SCLK rise during a frame, shift MOSI into a 16-bit rx register MSB-first and increment a 5-bit bit counter that saturates at 16.
REQ-021 SHALL, on SS_n rise with bit counter == 16, set the channel pointer to rx[13:11], so a command word is {2'b00, ch[2:0], 11'h000}.
REQ-022 SHALL, on SS_n rise with bit counter != 16, leave the channel pointer unchanged.
REQ-023 SHALL make the channel pointer set by frame N select the data returned in frame N+1 (one-frame pipeline).
REQ-024 SHALL drive MISO to 1'b0 while SS_n is high (no tri-state).
REQ-025 SHALL ignore SCLK edges while SS_n is high.
REQ-026 SHALL, when SS_n rises and falls in the same or adjacent clk cycles, process the rise (pointer update) before the fall (tx load).
REQ-027 SHALL use the updated pointer for that tx load.

Reset
REQ-028 SHALL, while rst is high, clear the channel pointer to 0, the tx and rx registers to 0, the bit counter to 0, and set MISO to 0.
REQ-029 SHALL load the synchronizer flops to idle values: SS_n=1, SCLK=1, MOSI=0.
REQ-030 SHALL, on reset asserted mid-frame, abort the frame with no pointer update.
REQ-031 SHALL, after reset deasserts, not start a frame until a fresh SS_n falling edge.
REQ-032 SHALL return channel 0 data in the first frame after reset.

Verification
REQ-033 SHALL pass: reset, then ld_cell_lft=12'h400, one frame sending 16'h0000 -> MISO reads 16'h0400.
REQ-034 SHALL pass: frame sending 16'h2800 (ch5), then frame sending 16'h3000 (ch6), with steerPot=12'h800, batt=12'hFFF -> second frame reads 16'h0800, third frame reads 16'h0FFF.
REQ-035 SHALL pass: frame sending 16'h2000 (ch4), with ld_cell_rght=12'h400 changed to 12'h000 mid-next-frame -> next frame still reads 16'h0400; the following frame reads 16'h0000.
REQ-036 SHALL pass: command selecting ch3 (16'h1800) -> next frame reads 16'h0000.
REQ-037 SHALL pass: frame aborted after 8 SCLK edges with 16'h3000 bits -> pointer unchanged, next frame returns the prior channel's data.
REQ-038 SHALL pass: rst pulsed mid-frame -> MISO=0, pointer=0, next full frame returns ld_cell_lft.
